// File: rtl/shot_clock_decoder_if.sv
// -----------------------------------------------------------------------------
// shot_clock_decoder_if
// Bundles the shot-clock display bus with the monitor's result signals.
//   seg_tens / seg_ones : active-low seven-segment bytes {dp,g,f,e,d,c,b,a}
//   secs                : decoded seconds value, 0..24
//   valid               : secs reflects the current sample
//   expire              : one-cycle pulse when the clock reaches zero
//   buzzer              : stretched expiry output
//   code_err / seq_err  : sticky error flags
// master = the side that drives the segment bytes, slave = the decoder.
// -----------------------------------------------------------------------------
interface shot_clock_decoder_if;
  logic [7:0] seg_tens;
  logic [7:0] seg_ones;
  logic [4:0] secs;
  logic       valid;
  logic       expire;
  logic       buzzer;
  logic       code_err;
  logic       seq_err;

  modport master (
    output seg_tens, seg_ones,
    input  secs, valid, expire, buzzer, code_err, seq_err
  );

  modport slave (
    input  seg_tens, seg_ones,
    output secs, valid, expire, buzzer, code_err, seq_err
  );
endinterface

// File: rtl/shot_clock_decoder.sv
// -----------------------------------------------------------------------------
// shot_clock_decoder
// Independent receive-side monitor for the 24-second shot-clock display.
// Decodes the two active-low segment bytes back to a seconds value, flags
// illegal segment codes and illegal countdown steps, and produces an expiry
// pulse plus a buzzer stretched to BUZZ_CYCLES cycles.
// Ports:
//   clock : system clock, rising edge
//   key2  : synchronous active-low reset
//   bus   : shot_clock_decoder_if.slave (segment inputs, decoded outputs)
// All outputs are registered: values after edge k reflect inputs at edge k.
// -----------------------------------------------------------------------------
module shot_clock_decoder #(
  parameter int unsigned BUZZ_CYCLES = 8  // 1..255
) (
  input  logic                  clock,
  input  logic                  key2,
  shot_clock_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,  // no reference value held
    ST_TRACK = 2'd1,  // previous good value held in r_secs
    ST_FAULT = 2'd2   // error seen; sequence checking off until reset
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] BUZZ_LOAD = 8'(BUZZ_CYCLES);

  // Returns {legal, digit}; digit is meaningless when legal is 0.
  function automatic logic [4:0] f_decode(input logic [7:0] seg);
    logic [4:0] d;
    case (seg)
      8'hC0:   d = {1'b1, 4'd0};
      8'hF9:   d = {1'b1, 4'd1};
      8'hA4:   d = {1'b1, 4'd2};
      8'hB0:   d = {1'b1, 4'd3};
      8'h99:   d = {1'b1, 4'd4};
      8'h92:   d = {1'b1, 4'd5};
      8'h82:   d = {1'b1, 4'd6};
      8'hF8:   d = {1'b1, 4'd7};
      8'h80:   d = {1'b1, 4'd8};
      8'h90:   d = {1'b1, 4'd9};
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  state_t     r_state;
  logic [4:0] r_secs;
  logic       r_valid;
  logic       r_expire;
  logic       r_buzzer;
  logic       r_code_err;
  logic       r_seq_err;
  logic [7:0] r_timer;

  logic [4:0] w_tens_dec;
  logic [4:0] w_ones_dec;
  logic       w_tens_blank;
  logic       w_ones_blank;
  logic       w_blank;
  logic [4:0] w_value;
  logic       w_code_err;
  logic       w_good;
  logic       w_seq_ok;
  logic       w_expire;
  logic [7:0] w_timer_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_tens_dec   = f_decode(bus.seg_tens);
    w_ones_dec   = f_decode(bus.seg_ones);
    w_tens_blank = (bus.seg_tens == SEG_BLANK);
    w_ones_blank = (bus.seg_ones == SEG_BLANK);
    w_blank      = w_tens_blank && w_ones_blank;

    // tens is range-checked below, so the 5-bit product never overflows
    // on any sample that is actually accepted.
    w_value = ({1'b0, w_tens_dec[3:0]} * 5'd10) + {1'b0, w_ones_dec[3:0]};

    w_code_err = 1'b0;
    if (!w_blank) begin
      w_code_err = (!w_tens_dec[4] && !w_tens_blank)
                || (!w_ones_dec[4] && !w_ones_blank)
                || (w_tens_blank != w_ones_blank)
                || (w_tens_dec[3:0] > 4'd2)
                || (w_value > 5'd24);
    end
    w_good = !w_blank && !w_code_err;

    // Legal steps from previous value r_secs: hold, count down, reload, wrap.
    w_seq_ok = (w_value == r_secs)
            || ((r_secs != 5'd0) && (w_value == r_secs - 5'd1))
            || (w_value == 5'd24)
            || ((w_value == 5'd23) && (r_secs == 5'd0));

    w_expire = w_good && (w_value == 5'd0)
            && ((r_state == ST_WAIT) || (r_secs != 5'd0));

    w_timer_next = 8'd0;
    if (w_expire)             w_timer_next = BUZZ_LOAD;
    else if (r_timer != 8'd0) w_timer_next = r_timer - 8'd1;
  end

  // NOTE: reset is sampled on the clock edge only; key2 is not in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!key2) begin
      r_state    <= ST_WAIT;
      r_secs     <= 5'd0;
      r_valid    <= 1'b0;
      r_expire   <= 1'b0;
      r_buzzer   <= 1'b0;
      r_code_err <= 1'b0;
      r_seq_err  <= 1'b0;
      r_timer    <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_expire <= w_expire;
      r_timer  <= w_timer_next;
      r_buzzer <= (w_timer_next != 8'd0);

      if (w_blank) begin
        r_valid <= 1'b0;
        if (r_state != ST_FAULT) r_state <= ST_WAIT;
      end else if (w_code_err) begin
        // A code error masks any sequence check on the same sample.
        r_code_err <= 1'b1;
        r_valid    <= 1'b0;
        r_state    <= ST_FAULT;
      end else begin
        r_secs  <= w_value;
        r_valid <= 1'b1;
        case (r_state)
          ST_WAIT:  r_state <= ST_TRACK;
          ST_TRACK: begin
            if (!w_seq_ok) begin
              r_seq_err <= 1'b1;
              r_state   <= ST_FAULT;
            end
          end
          default:  r_state <= ST_FAULT;
        endcase
      end
    end
  end

  assign bus.secs     = r_secs;
  assign bus.valid    = r_valid;
  assign bus.expire   = r_expire;
  assign bus.buzzer   = r_buzzer;
  assign bus.code_err = r_code_err;
  assign bus.seq_err  = r_seq_err;

endmodule
